// File: rtl/readop_lane.sv
// -----------------------------------------------------------------------------
// readop_lane
//
// One lane of the read-operand (RO) stage. It accepts one issued uop per cycle
// from the reservation station and reads its sources from the physical
// register file through a synchronous read port. It then hands a fully
// resolved operand bundle to the execution units.
//
// Pipeline:
//   S1 : PRF read in flight. PRF data arrives on the first cycle after accept.
//        If S1 cannot advance on that cycle, the resolved operands are latched
//        into a hold register. From then on prf_rdata is never looked at again
//        for this uop.
//   S2 : output register. It drives ex_* and holds them stable under
//        back-pressure.
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   flush              discard everything in flight at the next edge
//   ro_*               issue handshake (ro_valid/ro_ready) and uop payload
//   prf_raddrN/reN     PRF read address and strobe (combinational on accept)
//   prf_rdataN         PRF read data, valid one cycle after the strobe
//   wb_valid/prd/dat   writeback ports, used only by the same-cycle bypass
//   ex_*               execution handshake (ex_valid/ex_ready), payload and
//                      resolved operands
//
// Optional feature (compile-time macro READOP_WB_BYPASS_EN):
//   defined   - a source that matches a writeback in its accept cycle captures
//               the writeback data. The lowest-numbered matching port wins.
//   undefined - the wb_* ports are ignored and the PRF must be write-through.
// -----------------------------------------------------------------------------
module readop_lane #(
  parameter int CONFIG_DW             = 64,
  parameter int CONFIG_P_ROB_DEPTH    = 4,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int PRF_AW                = 6,
  parameter int PC_W                  = 30,
  parameter int UOP_W                 = 32,
  parameter int WB_N                  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  // issue side
  input  logic                             ro_valid,
  output logic                             ro_ready,
  input  logic [UOP_W-1:0]                 ro_uop,
  input  logic [CONFIG_DW-1:0]             ro_imm,
  input  logic [PC_W-1:0]                  ro_pc,
  input  logic [PRF_AW-1:0]                ro_prs1,
  input  logic [PRF_AW-1:0]                ro_prs2,
  input  logic                             ro_prs1_re,
  input  logic                             ro_prs2_re,
  input  logic [PRF_AW-1:0]                ro_prd,
  input  logic                             ro_prd_we,
  input  logic [CONFIG_P_ROB_DEPTH-1:0]    ro_rob_id,
  input  logic [CONFIG_P_COMMIT_WIDTH-1:0] ro_rob_bank,
  // PRF read port
  output logic [PRF_AW-1:0]                prf_raddr1,
  output logic [PRF_AW-1:0]                prf_raddr2,
  output logic                             prf_re1,
  output logic                             prf_re2,
  input  logic [CONFIG_DW-1:0]             prf_rdata1,
  input  logic [CONFIG_DW-1:0]             prf_rdata2,
  // writeback ports
  input  logic [WB_N-1:0]                  wb_valid,
  input  logic [WB_N*PRF_AW-1:0]           wb_prd,
  input  logic [WB_N*CONFIG_DW-1:0]        wb_dat,
  // execution side
  output logic                             ex_valid,
  input  logic                             ex_ready,
  output logic [UOP_W-1:0]                 ex_uop,
  output logic [CONFIG_DW-1:0]             ex_imm,
  output logic [PC_W-1:0]                  ex_pc,
  output logic [PRF_AW-1:0]                ex_prd,
  output logic                             ex_prd_we,
  output logic [CONFIG_P_ROB_DEPTH-1:0]    ex_rob_id,
  output logic [CONFIG_P_COMMIT_WIDTH-1:0] ex_rob_bank,
  output logic [CONFIG_DW-1:0]             ex_operand1,
  output logic [CONFIG_DW-1:0]             ex_operand2
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // S1
  logic                             s1_valid_q,    s1_valid_d;
  logic [UOP_W-1:0]                 s1_uop_q,      s1_uop_d;
  logic [CONFIG_DW-1:0]             s1_imm_q,      s1_imm_d;
  logic [PC_W-1:0]                  s1_pc_q,       s1_pc_d;
  logic [PRF_AW-1:0]                s1_prd_q,      s1_prd_d;
  logic                             s1_prd_we_q,   s1_prd_we_d;
  logic [CONFIG_P_ROB_DEPTH-1:0]    s1_rob_id_q,   s1_rob_id_d;
  logic [CONFIG_P_COMMIT_WIDTH-1:0] s1_rob_bank_q, s1_rob_bank_d;
  logic                             s1_re1_q,      s1_re1_d;
  logic                             s1_re2_q,      s1_re2_d;
  logic                             s1_held_q,     s1_held_d;
  logic [CONFIG_DW-1:0]             s1_hold1_q,    s1_hold1_d;
  logic [CONFIG_DW-1:0]             s1_hold2_q,    s1_hold2_d;
`ifdef READOP_WB_BYPASS_EN
  logic                             s1_byp1_q,     s1_byp1_d;
  logic                             s1_byp2_q,     s1_byp2_d;
  logic [CONFIG_DW-1:0]             s1_bdat1_q,    s1_bdat1_d;
  logic [CONFIG_DW-1:0]             s1_bdat2_q,    s1_bdat2_d;
`endif
  // S2 (drives ex_* directly)
  logic                             s2_valid_q,    s2_valid_d;
  logic [UOP_W-1:0]                 ex_uop_q,      ex_uop_d;
  logic [CONFIG_DW-1:0]             ex_imm_q,      ex_imm_d;
  logic [PC_W-1:0]                  ex_pc_q,       ex_pc_d;
  logic [PRF_AW-1:0]                ex_prd_q,      ex_prd_d;
  logic                             ex_prd_we_q,   ex_prd_we_d;
  logic [CONFIG_P_ROB_DEPTH-1:0]    ex_rob_id_q,   ex_rob_id_d;
  logic [CONFIG_P_COMMIT_WIDTH-1:0] ex_rob_bank_q, ex_rob_bank_d;
  logic [CONFIG_DW-1:0]             ex_op1_q,      ex_op1_d;
  logic [CONFIG_DW-1:0]             ex_op2_q,      ex_op2_d;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s2_free;
  logic s1_adv;
  logic accept;

  always_comb begin
    s2_free  = !s2_valid_q || ex_ready;
    s1_adv   = s2_free;
    // S1 can take a new uop when it is empty or is emptying this cycle.
    ro_ready = !flush && (!s1_valid_q || s1_adv);
    accept   = ro_valid && ro_ready;

    prf_raddr1 = ro_prs1;
    prf_raddr2 = ro_prs2;
    prf_re1    = accept && ro_prs1_re;
    prf_re2    = accept && ro_prs2_re;
  end

  // ---------------------------------------------------------------------------
  // Same-cycle writeback bypass
  // ---------------------------------------------------------------------------
`ifdef READOP_WB_BYPASS_EN
  logic                 byp1_hit, byp2_hit;
  logic [CONFIG_DW-1:0] byp1_dat, byp2_dat;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    byp1_hit = 1'b0;
    byp2_hit = 1'b0;
    byp1_dat = '0;
    byp2_dat = '0;
    // Scan from the highest port down so the lowest matching port is the
    // last assignment and therefore wins.
    for (int k = WB_N - 1; k >= 0; k--) begin
      if (wb_valid[k] && (wb_prd[k*PRF_AW +: PRF_AW] == ro_prs1)) begin
        byp1_hit = 1'b1;
        byp1_dat = wb_dat[k*CONFIG_DW +: CONFIG_DW];
      end
      if (wb_valid[k] && (wb_prd[k*PRF_AW +: PRF_AW] == ro_prs2)) begin
        byp2_hit = 1'b1;
        byp2_dat = wb_dat[k*CONFIG_DW +: CONFIG_DW];
      end
    end
  end
`else
  // The PRF is write-through in this build, so the writeback ports carry
  // nothing this lane needs.
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_prd, wb_dat};
`endif

  // ---------------------------------------------------------------------------
  // Operand resolution in S1
  // ---------------------------------------------------------------------------
  logic [CONFIG_DW-1:0] s1_op1, s1_op2;

  always_comb begin
    s1_op1 = '0;
    s1_op2 = '0;
    if (s1_held_q) begin
      // prf_rdata is only valid on the first S1 cycle. After that the hold
      // register is the only trusted copy.
      s1_op1 = s1_hold1_q;
      s1_op2 = s1_hold2_q;
    end else begin
`ifdef READOP_WB_BYPASS_EN
      if (s1_re1_q) s1_op1 = s1_byp1_q ? s1_bdat1_q : prf_rdata1;
      if (s1_re2_q) s1_op2 = s1_byp2_q ? s1_bdat2_q : prf_rdata2;
`else
      if (s1_re1_q) s1_op1 = prf_rdata1;
      if (s1_re2_q) s1_op2 = prf_rdata2;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_uop_d      = s1_uop_q;
    s1_imm_d      = s1_imm_q;
    s1_pc_d       = s1_pc_q;
    s1_prd_d      = s1_prd_q;
    s1_prd_we_d   = s1_prd_we_q;
    s1_rob_id_d   = s1_rob_id_q;
    s1_rob_bank_d = s1_rob_bank_q;
    s1_re1_d      = s1_re1_q;
    s1_re2_d      = s1_re2_q;
    s1_held_d     = s1_held_q;
    s1_hold1_d    = s1_hold1_q;
    s1_hold2_d    = s1_hold2_q;
`ifdef READOP_WB_BYPASS_EN
    s1_byp1_d     = s1_byp1_q;
    s1_byp2_d     = s1_byp2_q;
    s1_bdat1_d    = s1_bdat1_q;
    s1_bdat2_d    = s1_bdat2_q;
`endif
    s2_valid_d    = s2_valid_q;
    ex_uop_d      = ex_uop_q;
    ex_imm_d      = ex_imm_q;
    ex_pc_d       = ex_pc_q;
    ex_prd_d      = ex_prd_q;
    ex_prd_we_d   = ex_prd_we_q;
    ex_rob_id_d   = ex_rob_id_q;
    ex_rob_bank_d = ex_rob_bank_q;
    ex_op1_d      = ex_op1_q;
    ex_op2_d      = ex_op2_q;

    // S1 occupancy: ro_ready already means "empty or leaving". Flush forces
    // ro_ready low, so the uop offered during a flush is dropped here.
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (ro_ready) begin
      s1_valid_d = ro_valid;
    end

    if (accept) begin
      s1_uop_d      = ro_uop;
      s1_imm_d      = ro_imm;
      s1_pc_d       = ro_pc;
      s1_prd_d      = ro_prd;
      s1_prd_we_d   = ro_prd_we;
      s1_rob_id_d   = ro_rob_id;
      s1_rob_bank_d = ro_rob_bank;
      s1_re1_d      = ro_prs1_re;
      s1_re2_d      = ro_prs2_re;
      s1_held_d     = 1'b0;
`ifdef READOP_WB_BYPASS_EN
      s1_byp1_d     = byp1_hit;
      s1_byp2_d     = byp2_hit;
      s1_bdat1_d    = byp1_dat;
      s1_bdat2_d    = byp2_dat;
`endif
    end else if (s1_valid_q && !s1_adv) begin
      // Stalled: freeze the resolved operands before the PRF port moves on.
      s1_held_d  = 1'b1;
      s1_hold1_d = s1_op1;
      s1_hold2_d = s1_op2;
    end

    // S2 occupancy and payload.
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_free) begin
      s2_valid_d = s1_valid_q;
    end

    if (!flush && s2_free && s1_valid_q) begin
      ex_uop_d      = s1_uop_q;
      ex_imm_d      = s1_imm_q;
      ex_pc_d       = s1_pc_q;
      ex_prd_d      = s1_prd_q;
      ex_prd_we_d   = s1_prd_we_q;
      ex_rob_id_d   = s1_rob_id_q;
      ex_rob_bank_d = s1_rob_bank_q;
      ex_op1_d      = s1_op1;
      ex_op2_d      = s1_op2;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples its pre-edge value regardless of statement order.
      s1_valid_q    <= 1'b0;
      s1_uop_q      <= '0;
      s1_imm_q      <= '0;
      s1_pc_q       <= '0;
      s1_prd_q      <= '0;
      s1_prd_we_q   <= 1'b0;
      s1_rob_id_q   <= '0;
      s1_rob_bank_q <= '0;
      s1_re1_q      <= 1'b0;
      s1_re2_q      <= 1'b0;
      s1_held_q     <= 1'b0;
      s1_hold1_q    <= '0;
      s1_hold2_q    <= '0;
`ifdef READOP_WB_BYPASS_EN
      s1_byp1_q     <= 1'b0;
      s1_byp2_q     <= 1'b0;
      s1_bdat1_q    <= '0;
      s1_bdat2_q    <= '0;
`endif
      s2_valid_q    <= 1'b0;
      ex_uop_q      <= '0;
      ex_imm_q      <= '0;
      ex_pc_q       <= '0;
      ex_prd_q      <= '0;
      ex_prd_we_q   <= 1'b0;
      ex_rob_id_q   <= '0;
      ex_rob_bank_q <= '0;
      ex_op1_q      <= '0;
      ex_op2_q      <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_uop_q      <= s1_uop_d;
      s1_imm_q      <= s1_imm_d;
      s1_pc_q       <= s1_pc_d;
      s1_prd_q      <= s1_prd_d;
      s1_prd_we_q   <= s1_prd_we_d;
      s1_rob_id_q   <= s1_rob_id_d;
      s1_rob_bank_q <= s1_rob_bank_d;
      s1_re1_q      <= s1_re1_d;
      s1_re2_q      <= s1_re2_d;
      s1_held_q     <= s1_held_d;
      s1_hold1_q    <= s1_hold1_d;
      s1_hold2_q    <= s1_hold2_d;
`ifdef READOP_WB_BYPASS_EN
      s1_byp1_q     <= s1_byp1_d;
      s1_byp2_q     <= s1_byp2_d;
      s1_bdat1_q    <= s1_bdat1_d;
      s1_bdat2_q    <= s1_bdat2_d;
`endif
      s2_valid_q    <= s2_valid_d;
      ex_uop_q      <= ex_uop_d;
      ex_imm_q      <= ex_imm_d;
      ex_pc_q       <= ex_pc_d;
      ex_prd_q      <= ex_prd_d;
      ex_prd_we_q   <= ex_prd_we_d;
      ex_rob_id_q   <= ex_rob_id_d;
      ex_rob_bank_q <= ex_rob_bank_d;
      ex_op1_q      <= ex_op1_d;
      ex_op2_q      <= ex_op2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ex_valid    = s2_valid_q;
  assign ex_uop      = ex_uop_q;
  assign ex_imm      = ex_imm_q;
  assign ex_pc       = ex_pc_q;
  assign ex_prd      = ex_prd_q;
  assign ex_prd_we   = ex_prd_we_q;
  assign ex_rob_id   = ex_rob_id_q;
  assign ex_rob_bank = ex_rob_bank_q;
  assign ex_operand1 = ex_op1_q;
  assign ex_operand2 = ex_op2_q;

endmodule

// File: tb/tb_readop_lane.sv
// -----------------------------------------------------------------------------
// tb_readop_lane
//
// Directed bench for readop_lane. A small synchronous PRF model answers the
// read strobes one cycle later. Its data lines can be forced to 0xDEAD to show
// that stalled operands come from the hold register. Inputs change 1 time unit
// after the rising edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_readop_lane;

  localparam int DW = 64;
  localparam int RD = 4;
  localparam int CW = 1;
  localparam int AW = 6;
  localparam int PW = 30;
  localparam int UW = 32;
  localparam int WN = 2;

  logic          clk, rst, flush;
  logic          ro_valid, ro_ready;
  logic [UW-1:0] ro_uop;
  logic [DW-1:0] ro_imm;
  logic [PW-1:0] ro_pc;
  logic [AW-1:0] ro_prs1, ro_prs2, ro_prd;
  logic          ro_prs1_re, ro_prs2_re, ro_prd_we;
  logic [RD-1:0] ro_rob_id;
  logic [CW-1:0] ro_rob_bank;
  logic [AW-1:0] prf_raddr1, prf_raddr2;
  logic          prf_re1, prf_re2;
  logic [DW-1:0] prf_rdata1, prf_rdata2;
  logic [WN-1:0]    wb_valid;
  logic [WN*AW-1:0] wb_prd;
  logic [WN*DW-1:0] wb_dat;
  logic          ex_valid, ex_ready;
  logic [UW-1:0] ex_uop;
  logic [DW-1:0] ex_imm;
  logic [PW-1:0] ex_pc;
  logic [AW-1:0] ex_prd;
  logic          ex_prd_we;
  logic [RD-1:0] ex_rob_id;
  logic [CW-1:0] ex_rob_bank;
  logic [DW-1:0] ex_operand1, ex_operand2;

  readop_lane dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ro_valid(ro_valid), .ro_ready(ro_ready), .ro_uop(ro_uop), .ro_imm(ro_imm),
    .ro_pc(ro_pc), .ro_prs1(ro_prs1), .ro_prs2(ro_prs2),
    .ro_prs1_re(ro_prs1_re), .ro_prs2_re(ro_prs2_re),
    .ro_prd(ro_prd), .ro_prd_we(ro_prd_we), .ro_rob_id(ro_rob_id),
    .ro_rob_bank(ro_rob_bank),
    .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
    .prf_re1(prf_re1), .prf_re2(prf_re2),
    .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2),
    .wb_valid(wb_valid), .wb_prd(wb_prd), .wb_dat(wb_dat),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_uop(ex_uop), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_prd(ex_prd), .ex_prd_we(ex_prd_we),
    .ex_rob_id(ex_rob_id), .ex_rob_bank(ex_rob_bank),
    .ex_operand1(ex_operand1), .ex_operand2(ex_operand2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PRF model: synchronous read, data on the cycle after the strobe.
  logic [DW-1:0] prf_mem [64];
  logic [DW-1:0] rd1_r, rd2_r;
  logic          corrupt;

  always @(posedge clk) begin
    if (prf_re1) rd1_r <= prf_mem[prf_raddr1];
    if (prf_re2) rd2_r <= prf_mem[prf_raddr2];
  end
  assign prf_rdata1 = corrupt ? 64'hDEAD : rd1_r;
  assign prf_rdata2 = corrupt ? 64'hDEAD : rd2_r;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_uop(input logic [AW-1:0] p1, input logic [AW-1:0] p2,
                           input logic re1, input logic re2,
                           input logic [RD-1:0] rob, input logic [PW-1:0] pc);
    ro_valid    = 1'b1;
    ro_prs1     = p1;
    ro_prs2     = p2;
    ro_prs1_re  = re1;
    ro_prs2_re  = re2;
    ro_rob_id   = rob;
    ro_pc       = pc;
    ro_uop      = 32'hA000_0000 | 32'(rob);
    ro_imm      = 64'h1000 + 64'(rob);
    ro_prd      = 6'd40 + 6'(rob);
    ro_prd_we   = 1'b1;
    ro_rob_bank = rob[0];
  endtask

  task automatic idle();
    ro_valid   = 1'b0;
    ro_prs1_re = 1'b0;
    ro_prs2_re = 1'b0;
  endtask

  logic [63:0] exp_byp;

  initial begin
    for (int i = 0; i < 64; i++) prf_mem[i] = 64'h100 + 64'(i);
    prf_mem[5] = 64'h11;
    prf_mem[7] = 64'h22;
    prf_mem[9] = 64'h0;
    rd1_r = '0; rd2_r = '0; corrupt = 1'b0;
    rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    wb_valid = '0; wb_prd = '0; wb_dat = '0;
    ro_uop = '0; ro_imm = '0; ro_pc = '0; ro_prs1 = '0; ro_prs2 = '0;
    ro_prs1_re = 1'b0; ro_prs2_re = 1'b0; ro_prd = '0; ro_prd_we = 1'b0;
    ro_rob_id = '0; ro_rob_bank = '0; ro_valid = 1'b0;

    // ---- reset state ----
    #2;
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_ex_op1", ex_operand1, 64'd0);
    check("rst_ex_pc", 64'(ex_pc), 64'd0);
    check("rst_ro_ready", 64'(ro_ready), 64'd1);
    @(negedge clk); rst = 1'b1;
    tick();

    // ---- single uop, latency 2 ----
    drive_uop(6'd5, 6'd7, 1'b1, 1'b1, 4'd3, 30'h123);
    @(negedge clk);
    check("t1_ro_ready", 64'(ro_ready), 64'd1);
    check("t1_prf_re1", 64'(prf_re1), 64'd1);
    check("t1_raddr1", 64'(prf_raddr1), 64'd5);
    check("t1_raddr2", 64'(prf_raddr2), 64'd7);
    tick(); idle();
    @(negedge clk);
    check("t1_lat_valid", 64'(ex_valid), 64'd0);
    tick();
    @(negedge clk);
    check("t1_ex_valid", 64'(ex_valid), 64'd1);
    check("t1_op1", ex_operand1, 64'h11);
    check("t1_op2", ex_operand2, 64'h22);
    check("t1_rob_id", 64'(ex_rob_id), 64'd3);
    check("t1_pc", 64'(ex_pc), 64'h123);
    check("t1_uop", 64'(ex_uop), 64'hA000_0003);
    check("t1_prd", 64'(ex_prd), 64'd43);
    tick();
    @(negedge clk);
    check("t1_drain", 64'(ex_valid), 64'd0);
    tick();

    // ---- back-to-back four uops ----
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive_uop(6'(10 + k), 6'(20 + k), 1'b1, 1'b1, 4'(k), 30'(k));
      else idle();
      @(negedge clk);
      if (k < 4) check($sformatf("b2b_ready%0d", k), 64'(ro_ready), 64'd1);
      if (k >= 2) begin
        check($sformatf("b2b_valid%0d", k), 64'(ex_valid), 64'd1);
        check($sformatf("b2b_rob%0d", k), 64'(ex_rob_id), 64'(k - 2));
        check($sformatf("b2b_op1_%0d", k), ex_operand1, 64'h10A + 64'(k - 2));
        check($sformatf("b2b_op2_%0d", k), ex_operand2, 64'h114 + 64'(k - 2));
      end
      tick();
    end
    @(negedge clk);
    check("b2b_end", 64'(ex_valid), 64'd0);
    tick();

    // ---- back-pressure with PRF lines changing ----
    ex_ready = 1'b0;
    drive_uop(6'd5, 6'd7, 1'b1, 1'b1, 4'd1, 30'h10);   // A
    tick();
    drive_uop(6'd10, 6'd11, 1'b1, 1'b1, 4'd2, 30'h20); // B
    @(negedge clk);
    check("bp_acceptB", 64'(ro_ready), 64'd1);
    tick();
    drive_uop(6'd12, 6'd13, 1'b1, 1'b1, 4'd3, 30'h30); // C, must wait
    for (int c = 0; c < 5; c++) begin
      if (c == 1) corrupt = 1'b1;
      @(negedge clk);
      check($sformatf("bp_ready%0d", c), 64'(ro_ready), 64'd0);
      check($sformatf("bp_valid%0d", c), 64'(ex_valid), 64'd1);
      check($sformatf("bp_rob%0d", c), 64'(ex_rob_id), 64'd1);
      check($sformatf("bp_op1_%0d", c), ex_operand1, 64'h11);
      tick();
    end
    idle();
    ex_ready = 1'b1;
    @(negedge clk);
    check("bp_relA_rob", 64'(ex_rob_id), 64'd1);
    check("bp_relA_op2", ex_operand2, 64'h22);
    tick();
    @(negedge clk);
    check("bp_relB_valid", 64'(ex_valid), 64'd1);
    check("bp_relB_rob", 64'(ex_rob_id), 64'd2);
    check("bp_relB_op1", ex_operand1, 64'h10A);
    check("bp_relB_op2", ex_operand2, 64'h10B);
    tick();
    corrupt = 1'b0;
    @(negedge clk);
    check("bp_drain", 64'(ex_valid), 64'd0);
    tick();

    // ---- same-cycle writeback bypass ----
`ifdef READOP_WB_BYPASS_EN
    exp_byp = 64'hABC;
`else
    exp_byp = 64'h0;
`endif
    drive_uop(6'd9, 6'd4, 1'b1, 1'b1, 4'd5, 30'h50);
    wb_valid = 2'b11;
    wb_prd   = {6'd9, 6'd7};
    wb_dat   = {64'hABC, 64'h555};
    tick();
    // Both ports hit prs1=7: port 0 must win when bypass is built in.
    drive_uop(6'd7, 6'd4, 1'b1, 1'b1, 4'd6, 30'h60);
    wb_prd   = {6'd7, 6'd7};
    wb_dat   = {64'h666, 64'h555};
    tick();
    idle();
    wb_valid = '0;
    @(negedge clk);
    check("byp_op1", ex_operand1, exp_byp);
    check("byp_op2", ex_operand2, 64'h104);
    tick();
    @(negedge clk);
`ifdef READOP_WB_BYPASS_EN
    exp_byp = 64'h555;
`else
    exp_byp = 64'h22;
`endif
    check("byp_low_k", ex_operand1, exp_byp);
    tick();

    // ---- read enable off ----
    drive_uop(6'd5, 6'd3, 1'b1, 1'b0, 4'd7, 30'h70);
    @(negedge clk);
    check("re_off_prf_re2", 64'(prf_re2), 64'd0);
    check("re_off_prf_re1", 64'(prf_re1), 64'd1);
    tick(); idle(); tick();
    @(negedge clk);
    check("re_off_op2", ex_operand2, 64'd0);
    check("re_off_op1", ex_operand1, 64'h11);
    tick(); tick();

    // ---- flush with both stages full, ex_ready rising with it ----
    ex_ready = 1'b0;
    drive_uop(6'd5, 6'd7, 1'b1, 1'b1, 4'd8, 30'h80);
    tick();
    drive_uop(6'd10, 6'd11, 1'b1, 1'b1, 4'd9, 30'h90);
    tick();
    drive_uop(6'd12, 6'd13, 1'b1, 1'b1, 4'd10, 30'hA0);
    @(negedge clk);
    check("fl_full_valid", 64'(ex_valid), 64'd1);
    check("fl_full_ready", 64'(ro_ready), 64'd0);
    tick();
    flush = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk);
    check("fl_ro_ready", 64'(ro_ready), 64'd0);
    check("fl_prf_re1", 64'(prf_re1), 64'd0);
    tick();
    flush = 1'b0;
    idle();
    @(negedge clk);
    check("fl_ex_valid", 64'(ex_valid), 64'd0);
    check("fl_ready_back", 64'(ro_ready), 64'd1);
    tick();
    @(negedge clk);
    check("fl_no_ghost", 64'(ex_valid), 64'd0);
    tick();

    // ---- asynchronous reset mid-stall ----
    ex_ready = 1'b0;
    drive_uop(6'd5, 6'd7, 1'b1, 1'b1, 4'd11, 30'hB0);
    tick();
    drive_uop(6'd10, 6'd11, 1'b1, 1'b1, 4'd12, 30'hC0);
    tick();
    idle();
    @(negedge clk);
    check("ar_pre_valid", 64'(ex_valid), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("ar_ex_valid", 64'(ex_valid), 64'd0);
    check("ar_ex_op1", ex_operand1, 64'd0);
    check("ar_ex_rob", 64'(ex_rob_id), 64'd0);
    check("ar_ro_ready", 64'(ro_ready), 64'd1);
    @(negedge clk); rst = 1'b1;
    tick();
    @(negedge clk);
    check("ar_after", 64'(ex_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
